// File: rtl/l2_mp_trace_pkg.sv
// Shared types for the L2 MainPipe trace buffer.
// Record layout, channel encodings and stat widths.
package l2_mp_trace_pkg;

  localparam int WAY_BITS   = 2;
  localparam int SET_BITS   = 7;
  localparam int TAG_BITS   = 8;
  localparam int MSHR_BITS  = 8;
  localparam int STAMP_BITS = 64;
  localparam int DROP_CNT_W = 32;

  localparam logic [2:0] CH_A = 3'd1;
  localparam logic [2:0] CH_B = 3'd2;
  localparam logic [2:0] CH_C = 3'd4;

  typedef struct packed {
    logic [WAY_BITS-1:0]   metaWway;
    logic                  metaWvalid;
    logic [MSHR_BITS-1:0]  mshrId;
    logic [MSHR_BITS-1:0]  allocPtr;
    logic                  allocValid;
    logic [WAY_BITS-1:0]   dirWay;
    logic                  dirHit;
    logic [SET_BITS-1:0]   sset;
    logic [TAG_BITS-1:0]   tag;
    logic [2:0]            opcode;
    logic [2:0]            channel;
    logic                  mshrTask;
    logic [STAMP_BITS-1:0] stamp;
  } mp_rec_t;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + 6'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/l2_mp_trace_fifo.sv
// Generic synchronous FIFO, power-of-two depth.
// No bypass: an empty FIFO never presents data in the push cycle.
module l2_mp_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_push,
  input  logic [W-1:0]           i_data,
  input  logic                   i_pop,
  output logic [W-1:0]           o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_cnt == '0);
  assign o_full    = (r_cnt == (AW+1)'(DEPTH));
  assign o_level   = r_cnt;
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_data    = o_empty ? '0 : r_mem[r_rd];

  always_ff @(posedge i_clock) begin
    if (w_do_push) begin
      r_mem[r_wr] <= i_data;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) begin
        r_wr <= r_wr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/l2_mp_trace_buffer.sv
// MainPipe trace collector: per-slice filter and pending slot,
// round-robin merge into one FIFO, drop statistics.
module l2_mp_trace_buffer
  import l2_mp_trace_pkg::*;
#(
  parameter  int NUM_SLICES = 4,
  parameter  int DEPTH      = 16,
  localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1,
  localparam int LVL_W      = $clog2(DEPTH) + 1
) (
  input  logic                             i_clock,
  input  logic                             i_reset,
  input  logic                             i_en,
  input  logic [NUM_SLICES-1:0]            i_in_valid,
  input  mp_rec_t [NUM_SLICES-1:0]         i_in_rec,
  input  logic [7:0]                       i_cfg_chan_mask,
  input  logic                             i_cfg_hit_only,
  input  logic                             i_clear_stats,
  output logic                             o_out_valid,
  input  logic                             i_out_ready,
  output mp_rec_t                          o_out_rec,
  output logic [IDX_W-1:0]                 o_out_slice,
  output logic [LVL_W-1:0]                 o_level,
  output logic [DROP_CNT_W-1:0]            o_drop_cnt,
  output logic                             o_overflow
);

  localparam int PW = $bits(mp_rec_t) + IDX_W;

  mp_rec_t                 r_pend_rec [NUM_SLICES];
  logic [NUM_SLICES-1:0]   r_pend_vld;
  logic [IDX_W-1:0]        r_ptr;
  logic [DROP_CNT_W-1:0]   r_drop_cnt;
  logic                    r_overflow;

  logic [NUM_SLICES-1:0]   w_accept;
  logic [NUM_SLICES-1:0]   w_load;
  logic [NUM_SLICES-1:0]   w_drop;
  logic [NUM_SLICES-1:0]   w_gnt_oh;
  logic                    w_gnt_vld;
  logic [IDX_W-1:0]        w_gnt_idx;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_pop;
  logic                    w_can_write;
  logic [PW-1:0]           w_head;
  logic [5:0]              w_drop_n;
  logic [DROP_CNT_W:0]     w_sum;

  assign o_out_valid = ~w_empty;
  assign w_pop       = o_out_valid & i_out_ready;
  assign w_can_write = ~w_full | w_pop;

  // A pending slot can be refilled in the same cycle it is granted.
  for (genvar g = 0; g < NUM_SLICES; g++) begin : g_slice
    assign w_accept[g] = i_en & i_in_valid[g]
                       & i_cfg_chan_mask[i_in_rec[g].channel]
                       & (~i_cfg_hit_only | i_in_rec[g].dirHit);
    assign w_load[g]   = w_accept[g] & (~r_pend_vld[g] | w_gnt_oh[g]);
    assign w_drop[g]   = w_accept[g] & ~w_load[g];

    always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
        r_pend_vld[g] <= 1'b0;
        r_pend_rec[g] <= '0;
      end else if (w_load[g]) begin
        r_pend_vld[g] <= 1'b1;
        r_pend_rec[g] <= i_in_rec[g];
      end else if (w_gnt_oh[g]) begin
        r_pend_vld[g] <= 1'b0;
      end
    end
  end

  always_comb begin
    logic [IDX_W-1:0] j;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    j         = '0;
    for (int k = 0; k < NUM_SLICES; k++) begin
      j = IDX_W'((int'(r_ptr) + k) % NUM_SLICES);
      if (!w_gnt_vld && r_pend_vld[j]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = j;
      end
    end
    if (!w_can_write) begin
      w_gnt_vld = 1'b0;
    end
  end

  assign w_gnt_oh = w_gnt_vld ? (NUM_SLICES'(1) << w_gnt_idx) : '0;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_ptr <= '0;
    end else if (w_gnt_vld) begin
      r_ptr <= (w_gnt_idx == IDX_W'(NUM_SLICES - 1)) ? '0
                                                      : w_gnt_idx + 1'b1;
    end
  end

  assign w_drop_n = popcount32(32'(w_drop));
  assign w_sum    = {1'b0, r_drop_cnt} + (DROP_CNT_W+1)'(w_drop_n);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end else if (i_clear_stats) begin
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end else if (|w_drop) begin
      r_drop_cnt <= w_sum[DROP_CNT_W] ? '1 : w_sum[DROP_CNT_W-1:0];
      r_overflow <= 1'b1;
    end
  end

  assign o_drop_cnt = r_drop_cnt;
  assign o_overflow = r_overflow;

  l2_mp_trace_fifo #(
    .DEPTH (DEPTH),
    .W     (PW)
  ) u_fifo (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_push  (w_gnt_vld),
    .i_data  ({r_pend_rec[w_gnt_idx], w_gnt_idx}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (o_level)
  );

  assign o_out_rec   = w_head[PW-1:IDX_W];
  assign o_out_slice = w_head[IDX_W-1:0];

endmodule

// File: tb/tb_l2_mp_trace_buffer.sv
// Scoreboard bench for l2_mp_trace_buffer.
// Directed stimulus; monitor pops expectations on each handshake.
module tb_l2_mp_trace_buffer;
  import l2_mp_trace_pkg::*;

  logic            clk;
  logic            rst;
  logic            en;
  logic [3:0]      in_valid;
  mp_rec_t [3:0]   in_rec;
  logic [7:0]      mask;
  logic            hit_only;
  logic            clr;
  logic            out_valid;
  logic            out_ready;
  mp_rec_t         out_rec;
  logic [1:0]      out_slice;
  logic [4:0]      level;
  logic [31:0]     drop_cnt;
  logic            overflow;

  typedef struct packed {
    mp_rec_t    rec;
    logic [1:0] sl;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass;
  int   n_total;

  l2_mp_trace_buffer #(.NUM_SLICES(4), .DEPTH(16)) dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_en            (en),
    .i_in_valid      (in_valid),
    .i_in_rec        (in_rec),
    .i_cfg_chan_mask (mask),
    .i_cfg_hit_only  (hit_only),
    .i_clear_stats   (clr),
    .o_out_valid     (out_valid),
    .i_out_ready     (out_ready),
    .o_out_rec       (out_rec),
    .o_out_slice     (out_slice),
    .o_level         (level),
    .o_drop_cnt      (drop_cnt),
    .o_overflow      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic mp_rec_t mk(input int n, input logic [2:0] ch,
                                 input logic hit);
    mp_rec_t r;
    r            = '0;
    r.metaWway   = n[1:0];
    r.metaWvalid = n[0];
    r.mshrId     = 8'(n * 3 + 1);
    r.allocPtr   = 8'(n ^ 8'h5A);
    r.allocValid = ~n[0];
    r.dirWay     = n[2:1];
    r.dirHit     = hit;
    r.sset       = 7'(n * 5);
    r.tag        = 8'(n + 8'h30);
    r.opcode     = n[2:0];
    r.channel    = ch;
    r.mshrTask   = n[1];
    r.stamp      = 64'hC0DE_0000_0000_0000 + 64'(n) * 64'h1_0000_0001;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    in_valid = '0;
    clr      = 1'b0;
  endtask

  task automatic put(input logic [1:0] s, input mp_rec_t r);
    in_valid[s] = 1'b1;
    in_rec[s]   = r;
  endtask

  task automatic expect_out(input mp_rec_t r, input logic [1:0] s);
    exp_t e;
    e.rec = r;
    e.sl  = s;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while ((exp_q.size() != 0 || out_valid) && c < 300) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (c >= 300) begin
      n_total++;
      $display("FAIL drain_timeout: queue %0d left, out_valid %0b",
               exp_q.size(), out_valid);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_out: got slice %0d rec %h, want none",
                 out_slice, out_rec);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_rec", out_rec, e.rec);
        chk("out_slice", out_slice, e.sl);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    mp_rec_t a0, a1, a2;
    n_pass = 0; n_total = 0;
    rst = 1'b1; en = 1'b1; in_valid = '0; in_rec = '0;
    mask = 8'hFF; hit_only = 1'b0; clr = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;
    tick(); tick();

    a0 = mk(1, CH_A, 1'b1);
    put(2'd0, a0); expect_out(a0, 2'd0);
    tick();
    @(negedge clk);
    chk("lat_t1_valid", out_valid, 0);
    @(negedge clk);
    chk("lat_t2_valid", out_valid, 1);
    @(posedge clk); #1;
    wait_drain();
    chk("single_drop", drop_cnt, 0);

    a0 = mk(2, CH_B, 1'b0);
    put(2'd3, a0); expect_out(a0, 2'd3);
    tick();
    wait_drain();

    for (int b = 0; b < 2; b++) begin
      for (int s = 0; s < 4; s++) begin
        a0 = mk(10 + b * 4 + s, CH_C, s[0]);
        put(2'(s), a0); expect_out(a0, 2'(s));
      end
      tick();
      wait_drain();
    end
    chk("burst_drop", drop_cnt, 0);

    a0 = mk(20, CH_A, 1'b1); a1 = mk(21, CH_A, 1'b1);
    a2 = mk(22, CH_A, 1'b1);
    put(2'd0, a0); put(2'd1, a1); put(2'd2, a2);
    expect_out(a0, 2'd0); expect_out(a1, 2'd1); expect_out(a2, 2'd2);
    tick();
    put(2'd1, mk(23, CH_A, 1'b1));
    tick();
    wait_drain();
    chk("contend_drop", drop_cnt, 1);
    chk("contend_ovf", overflow, 1);

    clr = 1'b1;
    tick();
    chk("clear_drop", drop_cnt, 0);
    chk("clear_ovf", overflow, 0);
    mask = 8'h04; hit_only = 1'b1;
    put(2'd0, mk(30, CH_A, 1'b1)); tick();
    a0 = mk(31, CH_B, 1'b1);
    put(2'd0, a0); expect_out(a0, 2'd0); tick();
    put(2'd0, mk(32, CH_B, 1'b0)); tick();
    wait_drain();
    chk("filter_drop", drop_cnt, 0);
    mask = 8'hFF; hit_only = 1'b0;

    out_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      a0 = mk(40 + k, CH_A, 1'b0);
      put(2'd0, a0);
      if (k <= 16) expect_out(a0, 2'd0);
      tick();
    end
    tick(); tick();
    chk("full_level", level, 16);
    chk("full_drop", drop_cnt, 3);
    chk("full_ovf", overflow, 1);
    chk("head_hold", out_rec, mk(40, CH_A, 1'b0));
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("full_pop_level", level, 16);
    wait_drain();
    chk("drained_level", level, 0);

    a1 = mk(60, CH_C, 1'b1); a2 = mk(61, CH_C, 1'b1);
    put(2'd1, a1); put(2'd2, a2);
    expect_out(a1, 2'd1); expect_out(a2, 2'd2);
    tick();
    put(2'd2, mk(62, CH_C, 1'b1)); clr = 1'b1;
    tick();
    chk("clr_drop_same", drop_cnt, 0);
    chk("clr_ovf_same", overflow, 0);
    wait_drain();

    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      put(2'd0, mk(70 + k, CH_A, 1'b0));
      tick();
    end
    tick(); tick(); tick();
    chk("pre_rst_level", level, 5);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid", out_valid, 0);
    chk("rst_async_level", level, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    a0 = mk(80, CH_A, 1'b1);
    put(2'd0, a0); expect_out(a0, 2'd0);
    tick();
    wait_drain();
    chk("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
